// File: rtl/dcache_wb.sv
// dcache_wb - direct-mapped, write-back, write-allocate data cache.
//
// Sits between the MEM stage and a slower word-beat backing memory.
// Hits complete combinationally in IDLE; misses write back a dirty victim
// (WRITEBACK), then fetch the new line (REFILL), holding the pipeline via
// cpu_stall. FLUSH scans all lines and writes back every dirty one.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata/wstrb   CPU access, held until cpu_ready
//   cpu_rdata, cpu_ready     load data / access-complete (same cycle on hit)
//   cpu_stall                pipeline hold
//   flush_req, flush_done    write back all dirty lines / 1-cycle done pulse
//   mem_req/we/addr/wdata    beat request to backing memory, held until ack
//   mem_rdata, mem_ack       beat response
module dcache_wb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wstrb,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_ready,
    output logic                cpu_stall,
    input  logic                flush_req,
    output logic                flush_done,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);
    localparam int NB = DATA_W / 8;
    localparam int BB = $clog2(NB);
    localparam int WB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TB = ADDR_W - IB - WB - BB;

    typedef logic [TB-1:0] tag_t;
    typedef logic [IB-1:0] idx_t;
    typedef logic [WB-1:0] wrd_t;

    typedef struct packed {
        tag_t          tag;
        idx_t          idx;
        wrd_t          wrd;
        logic [BB-1:0] bsel;
    } addr_t;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, FLUSH} state_t;

    state_t state_q, state_d;

    // Line storage; data and tags are deliberately left unreset.
    logic [DATA_W-1:0]    data_q [NUM_LINES][LINE_WORDS];
    tag_t                 tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q, dirty_q;

    idx_t line_q;        // line currently being written back / refilled
    tag_t wb_tag_q;      // victim tag for write beats
    tag_t rf_tag_q;      // requested tag for read beats
    wrd_t beat_q;
    idx_t fidx_q;        // flush scan position
    logic flushing_q;    // WRITEBACK was entered from FLUSH
    logic flush_pend_q;
    logic mem_req_q;

    addr_t req;
    logic  unused_bsel;
    assign req         = addr_t'(cpu_addr);
    assign unused_bsel = ^req.bsel;

    logic hit, miss_go, xfer, beat_done, last_beat;
    logic flush_busy, flush_go, f_dirty, f_last;

    assign hit        = valid_q[req.idx] && (tag_q[req.idx] == req.tag);
    assign cpu_ready  = (state_q == IDLE) && cpu_req && hit;
    assign miss_go    = (state_q == IDLE) && cpu_req && !hit;
    assign xfer       = (state_q == WRITEBACK) || (state_q == REFILL);
    assign beat_done  = mem_req_q && mem_ack;
    assign last_beat  = (beat_q == wrd_t'(LINE_WORDS - 1));
    assign flush_busy = (state_q == FLUSH) || flushing_q;
    // A pending flush waits for an IDLE cycle with no CPU access.
    assign flush_go   = (state_q == IDLE) && !cpu_req && (flush_req || flush_pend_q);
    assign f_dirty    = valid_q[fidx_q] && dirty_q[fidx_q];
    assign f_last     = (fidx_q == idx_t'(NUM_LINES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (miss_go)
                    state_d = (valid_q[req.idx] && dirty_q[req.idx]) ? WRITEBACK : REFILL;
                else if (flush_go)
                    state_d = FLUSH;
            end
            WRITEBACK: if (beat_done && last_beat) state_d = flushing_q ? FLUSH : REFILL;
            REFILL:    if (beat_done && last_beat) state_d = IDLE;
            FLUSH: begin
                if (f_dirty)     state_d = WRITEBACK;
                else if (f_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            beat_q       <= '0;
            line_q       <= '0;
            wb_tag_q     <= '0;
            rf_tag_q     <= '0;
            fidx_q       <= '0;
            flushing_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            state_q <= state_d;
            // Request drops for one cycle after every ack, and rises one
            // cycle after entering a transfer state.
            if (beat_done) begin
                mem_req_q <= 1'b0;
                beat_q    <= beat_q + 1'b1;
            end else if (xfer) begin
                mem_req_q <= 1'b1;
            end
            if (miss_go) begin
                line_q   <= req.idx;
                wb_tag_q <= tag_q[req.idx];
                rf_tag_q <= req.tag;
            end
            if (flush_go) begin
                fidx_q       <= '0;
                flush_pend_q <= 1'b0;
            end else if (flush_req && !flush_busy) begin
                flush_pend_q <= 1'b1;
            end
            if (state_q == FLUSH) begin
                if (f_dirty) begin
                    line_q     <= fidx_q;
                    wb_tag_q   <= tag_q[fidx_q];
                    flushing_q <= 1'b1;
                end else if (!f_last) begin
                    fidx_q <= fidx_q + 1'b1;
                end
            end
            // Cleared line is rescanned once more as clean, then the scan moves on.
            if (state_q == WRITEBACK && beat_done && last_beat && flushing_q) begin
                flushing_q      <= 1'b0;
                dirty_q[line_q] <= 1'b0;
            end
            if (state_q == REFILL && beat_done && last_beat) begin
                valid_q[line_q] <= 1'b1;
                dirty_q[line_q] <= 1'b0;
            end
            if (cpu_ready && cpu_we)
                dirty_q[req.idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_ready && cpu_we) begin
            for (int b = 0; b < NB; b++)
                if (cpu_wstrb[b])
                    data_q[req.idx][req.wrd][8*b +: 8] <= cpu_wdata[8*b +: 8];
        end
        if (state_q == REFILL && beat_done) begin
            data_q[line_q][beat_q] <= mem_rdata;
            if (last_beat)
                tag_q[line_q] <= rf_tag_q;
        end
    end

    // Beat address/data are gated by mem_req so everything idles at 0.
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_req_q && (state_q == WRITEBACK);
    assign mem_addr   = mem_req_q ? {(state_q == WRITEBACK) ? wb_tag_q : rf_tag_q,
                                     line_q, beat_q, {BB{1'b0}}} : '0;
    assign mem_wdata  = mem_we ? data_q[line_q][beat_q] : '0;
    assign cpu_rdata  = cpu_ready ? data_q[req.idx][req.wrd] : '0;
    assign cpu_stall  = (cpu_req && !cpu_ready) || flush_busy;
    assign flush_done = (state_q == FLUSH) && !f_dirty && f_last;
endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb with a word-beat memory responder that logs
// every beat. Backing memory word at byte address A starts as 0xC0DE0000|A.
module tb_dcache_wb;
    logic        clk = 1'b0, rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready, cpu_stall;
    logic        flush_req = 1'b0, flush_done;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack, ack_r = 1'b0, spur_ack = 1'b0, ack_hold = 1'b0;

    assign mem_ack = ack_r | spur_ack;

    dcache_wb dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic        log_we[$];

    // Acks a beat one cycle after seeing mem_req, never two cycles running.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            if (mem_req && !ack_r && !ack_hold) begin
                ack_r <= 1'b1;
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_we);
                if (mem_we) begin
                    mem[mem_addr[11:2]] <= mem_wdata;
                    log_data.push_back(mem_wdata);
                end else begin
                    mem_rdata <= mem[mem_addr[11:2]];
                    log_data.push_back(mem[mem_addr[11:2]]);
                end
            end
        end
    end

    int n_assert = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int i, input logic we, input logic [31:0] a,
                            input logic [31:0] d);
        chk({tag, "_present"}, 32'(i < log_addr.size()), 1);
        if (i < log_addr.size()) begin
            chk({tag, "_we"}, 32'(log_we[i]), 32'(we));
            chk({tag, "_addr"}, log_addr[i], a);
            if (we) chk({tag, "_data"}, log_data[i], d);
        end
    endtask

    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] rd, output int cyc);
        bit done = 0;
        cyc = 0;
        rd  = '0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_wstrb = st;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (cpu_ready) begin
                done = 1;
                rd   = cpu_rdata;
            end else begin
                cyc++;
            end
        end
        chk({tag, "_completed"}, 32'(done), 1);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic wait_log(input string tag, input int n);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (log_addr.size() >= n) ok = 1;
        end
        chk({tag, "_log_wait"}, 32'(ok), 1);
    endtask

    task automatic wait_req(input string tag, input logic lvl);
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (mem_req === lvl) ok = 1;
        end
        chk({tag, "_req_wait"}, 32'(ok), 1);
    endtask

    logic [31:0] fl_a [8] = '{32'h500, 32'h504, 32'h508, 32'h50C,
                              32'h150, 32'h154, 32'h158, 32'h15C};
    logic [31:0] fl_d [8] = '{32'hC0DE0500, 32'hC0DE0504, 32'h11112222, 32'hC0DE050C,
                              32'hC0DE0150, 32'h33330154, 32'hC0DE0158, 32'hC0DE015C};

    initial begin
        logic [31:0] rd;
        int          cyc, base, pulses;
        bit          stable;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i * 4);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(cpu_ready), 0);
        chk("rst_stall", 32'(cpu_stall), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_flush_done", 32'(flush_done), 0);
        chk("rst_rdata", cpu_rdata, 0);
        rst = 1'b1;

        // 1: cold load, clean refill
        access("t1", 0, 32'h100, 0, 0, rd, cyc);
        chk("t1_latency", 32'(cyc), 13);
        chk("t1_rdata", rd, 32'hC0DE0100);
        chk("t1_beats", 32'(log_addr.size()), 4);
        for (int i = 0; i < 4; i++) chk_beat("t1_rd", i, 0, 32'h100 + 32'(4 * i), 0);

        // 2: partial store hit, then load back
        access("t2s", 1, 32'h104, 32'hDEADBEEF, 4'b0011, rd, cyc);
        chk("t2_store_latency", 32'(cyc), 0);
        access("t2l", 0, 32'h104, 0, 0, rd, cyc);
        chk("t2_load_latency", 32'(cyc), 0);
        chk("t2_rdata", rd, 32'hC0DEBEEF);
        chk("t2_no_traffic", 32'(log_addr.size()), 4);

        // 3: conflict miss with dirty victim
        base = log_addr.size();
        access("t3", 0, 32'h500, 0, 0, rd, cyc);
        chk("t3_latency", 32'(cyc), 25);
        chk("t3_rdata", rd, 32'hC0DE0500);
        chk("t3_beats", 32'(log_addr.size() - base), 8);
        chk_beat("t3_wb0", base + 0, 1, 32'h100, 32'hC0DE0100);
        chk_beat("t3_wb1", base + 1, 1, 32'h104, 32'hC0DEBEEF);
        chk_beat("t3_wb2", base + 2, 1, 32'h108, 32'hC0DE0108);
        chk_beat("t3_wb3", base + 3, 1, 32'h10C, 32'hC0DE010C);
        for (int i = 0; i < 4; i++) chk_beat("t3_rd", base + 4 + i, 0, 32'h500 + 32'(4 * i), 0);

        // 4: dirty lines 0 and 5, then flush (second flush_req absorbed)
        access("t4a", 1, 32'h508, 32'h11112222, 4'b1111, rd, cyc);
        access("t4b", 0, 32'h150, 0, 0, rd, cyc);
        chk("t4_line5_latency", 32'(cyc), 13);
        access("t4c", 1, 32'h154, 32'h33334444, 4'b1100, rd, cyc);
        base = log_addr.size();
        @(posedge clk); #1 flush_req = 1'b1;
        @(posedge clk); #1 flush_req = 1'b0;
        @(negedge clk);
        chk("t4_stall_in_flush", 32'(cpu_stall), 1);
        repeat (3) @(posedge clk);
        #1 flush_req = 1'b1;
        @(posedge clk); #1 flush_req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (flush_done) pulses++;
        end
        chk("t4_done_pulses", 32'(pulses), 1);
        chk("t4_beats", 32'(log_addr.size() - base), 8);
        for (int i = 0; i < 8; i++) chk_beat("t4_wb", base + i, 1, fl_a[i], fl_d[i]);
        access("t4d", 0, 32'h508, 0, 0, rd, cyc);
        chk("t4_hit_latency", 32'(cyc), 0);
        chk("t4_hit_rdata", rd, 32'h11112222);
        chk("t4_no_traffic", 32'(log_addr.size() - base), 8);

        // 5: ack stalled 10 cycles mid-refill
        base = log_addr.size();
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h920;
        wait_log("t5", base + 1);
        ack_hold = 1'b1;
        wait_req("t5_lo", 1'b0);
        wait_req("t5_hi", 1'b1);
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b1 || mem_addr !== 32'h924 || cpu_stall !== 1'b1) stable = 0;
        end
        chk("t5_hold_stable", 32'(stable), 1);
        chk("t5_hold_addr", mem_addr, 32'h924);
        ack_hold = 1'b0;
        stable = 0;
        for (int i = 0; i < 100 && !stable; i++) begin
            @(negedge clk);
            if (cpu_ready) begin stable = 1; rd = cpu_rdata; end
        end
        chk("t5_completed", 32'(stable), 1);
        chk("t5_rdata", rd, 32'hC0DE0920);
        @(posedge clk); #1 cpu_req = 1'b0;
        chk("t5_beats", 32'(log_addr.size() - base), 4);
        for (int i = 0; i < 4; i++) chk_beat("t5_rd", base + i, 0, 32'h920 + 32'(4 * i), 0);
        // Spurious ack while idle
        @(posedge clk); #1 spur_ack = 1'b1;
        @(posedge clk); #1 spur_ack = 1'b0;
        @(negedge clk);
        chk("t5_spur_req", 32'(mem_req), 0);
        chk("t5_spur_stall", 32'(cpu_stall), 0);
        access("t5h", 0, 32'h924, 0, 0, rd, cyc);
        chk("t5_spur_hit_latency", 32'(cyc), 0);
        chk("t5_spur_hit_rdata", rd, 32'hC0DE0924);

        // 6: reset during beat 2 of a refill
        base = log_addr.size();
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hA40;
        wait_log("t6", base + 2);
        wait_req("t6_lo", 1'b0);
        wait_req("t6_hi", 1'b1);
        chk("t6_beat2_addr", mem_addr, 32'hA48);
        rst = 1'b0; cpu_req = 1'b0;
        #1;
        chk("t6_rst_req", 32'(mem_req), 0);
        chk("t6_rst_addr", mem_addr, 0);
        chk("t6_rst_stall", 32'(cpu_stall), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        base = log_addr.size();
        access("t6r", 0, 32'hA40, 0, 0, rd, cyc);
        chk("t6_relatency", 32'(cyc), 13);
        chk("t6_rdata", rd, 32'hC0DE0A40);
        chk("t6_beats", 32'(log_addr.size() - base), 4);
        for (int i = 0; i < 4; i++) chk_beat("t6_rd", base + i, 0, 32'hA40 + 32'(4 * i), 0);
        // Reset dropped line 0; flushed data now comes back from memory.
        access("t6m", 0, 32'h508, 0, 0, rd, cyc);
        chk("t6_line0_latency", 32'(cyc), 13);
        chk("t6_line0_rdata", rd, 32'h11112222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
